// File: rtl/core_ctrl_pkg.sv
// Shared constants and types for the core_ctrl sequencer and its decoder.
package core_ctrl_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_B    = 4'b0001;
  localparam logic [3:0] MASK_H    = 4'b0011;
  localparam logic [3:0] MASK_W    = 4'b1111;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    STORE  = 3'd3,
    HALT   = 3'd4
  } state_e;

  // Byte-lane mask for a store width; lane shifting is left to the memory.
  function automatic logic [3:0] store_mask(input logic [2:0] f3);
    case (f3)
      F3_SB:   return MASK_B;
      F3_SH:   return MASK_H;
      default: return MASK_W;
    endcase
  endfunction

endpackage

// File: rtl/core_ctrl_instr_decode.sv
// Combinational field extraction, immediate generation and legality check.
module instr_decode
  import core_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm,
  output logic        is_system,
  output logic        is_illegal
);

  // Split the word into fields and classify it by opcode.
  always_comb begin
    opcode     = instr[6:0];
    func3      = instr[14:12];
    func7      = instr[31:25];
    rd         = instr[11:7];
    rs1        = instr[19:15];
    rs2        = instr[24:20];
    imm        = '0;
    is_system  = 1'b0;
    is_illegal = 1'b0;
    case (instr[6:0])
      OP_R: begin
        if (instr[31:25] == F7_ALT) begin
          is_illegal = !((instr[14:12] == 3'd0) || (instr[14:12] == 3'd5));
        end else if (instr[31:25] != F7_BASE) begin
          is_illegal = 1'b1;
        end
      end
      OP_I: begin
        rs2 = '0;
        imm = {{20{instr[31]}}, instr[31:20]};
      end
      OP_S: begin
        rd         = '0;
        imm        = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        is_illegal = (instr[14:12] > F3_SW);
      end
      OP_SYS: begin
        is_system = 1'b1;
      end
      default: begin
        is_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/core_ctrl.sv
// Multi-cycle RV32 sequencer: fetch, decode, execute/store, halt.
// Decoded fields are captured as the instruction arrives so they are stable
// for the whole DECODE cycle, ahead of any strobe.
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        reg_write,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [31:0] imm,
  output logic [3:0]  mem_write_enable,
  output logic        store_enable,
  output logic [31:0] pc,
  output logic [31:0] retired,
  output logic        halt,
  output logic        illegal
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] retired_q, retired_d;
  logic        imem_req_q, imem_req_d;
  logic        reg_write_q, reg_write_d;
  logic        store_enable_q, store_enable_d;
  logic [3:0]  mwe_q, mwe_d;
  logic        halt_q, halt_d;
  logic        illegal_q, illegal_d;
  logic [6:0]  opcode_q, opcode_d;
  logic [2:0]  func3_q, func3_d;
  logic [6:0]  func7_q, func7_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  rs1_q, rs1_d;
  logic [4:0]  rs2_q, rs2_d;
  logic [31:0] imm_q, imm_d;
  logic        dec_sys_q, dec_sys_d;
  logic        dec_ill_q, dec_ill_d;

  logic [6:0]  dc_opcode;
  logic [2:0]  dc_func3;
  logic [6:0]  dc_func7;
  logic [4:0]  dc_rd;
  logic [4:0]  dc_rs1;
  logic [4:0]  dc_rs2;
  logic [31:0] dc_imm;
  logic        dc_sys;
  logic        dc_ill;

  instr_decode u_decode (
    .instr      (imem_rdata),
    .opcode     (dc_opcode),
    .func3      (dc_func3),
    .func7      (dc_func7),
    .rd         (dc_rd),
    .rs1        (dc_rs1),
    .rs2        (dc_rs2),
    .imm        (dc_imm),
    .is_system  (dc_sys),
    .is_illegal (dc_ill)
  );

  // Next-state and next-output logic; strobes default low every cycle.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    retired_d      = retired_q;
    imem_req_d     = imem_req_q;
    reg_write_d    = 1'b0;
    store_enable_d = 1'b0;
    mwe_d          = MASK_NONE;
    halt_d         = halt_q;
    illegal_d      = illegal_q;
    opcode_d       = opcode_q;
    func3_d        = func3_q;
    func7_d        = func7_q;
    rd_d           = rd_q;
    rs1_d          = rs1_q;
    rs2_d          = rs2_q;
    imm_d          = imm_q;
    dec_sys_d      = dec_sys_q;
    dec_ill_d      = dec_ill_q;
    case (state_q)
      FETCH: begin
        imem_req_d = 1'b1;
        if (imem_valid) begin
          imem_req_d = 1'b0;
          opcode_d   = dc_opcode;
          func3_d    = dc_func3;
          func7_d    = dc_func7;
          rd_d       = dc_rd;
          rs1_d      = dc_rs1;
          rs2_d      = dc_rs2;
          imm_d      = dc_imm;
          dec_sys_d  = dc_sys;
          dec_ill_d  = dc_ill;
          state_d    = DECODE;
        end
      end
      DECODE: begin
        if (dec_ill_q) begin
          halt_d    = 1'b1;
          illegal_d = 1'b1;
          state_d   = HALT;
        end else if (dec_sys_q) begin
          halt_d  = 1'b1;
          state_d = HALT;
        end else begin
          reg_write_d = (opcode_q != OP_S);
          state_d     = EXEC;
        end
      end
      EXEC: begin
        if (opcode_q == OP_S) begin
          store_enable_d = 1'b1;
          mwe_d          = store_mask(func3_q);
          state_d        = STORE;
        end else begin
          pc_d       = pc_q + 32'd4;
          retired_d  = retired_q + 32'd1;
          imem_req_d = 1'b1;
          state_d    = FETCH;
        end
      end
      STORE: begin
        pc_d       = pc_q + 32'd4;
        retired_d  = retired_q + 32'd1;
        imem_req_d = 1'b1;
        state_d    = FETCH;
      end
      HALT: begin
        imem_req_d = 1'b0;
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  // State register; reset clears every strobe immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= FETCH;
      pc_q           <= RESET_PC;
      retired_q      <= '0;
      imem_req_q     <= 1'b0;
      reg_write_q    <= 1'b0;
      store_enable_q <= 1'b0;
      mwe_q          <= MASK_NONE;
      halt_q         <= 1'b0;
      illegal_q      <= 1'b0;
      opcode_q       <= '0;
      func3_q        <= '0;
      func7_q        <= '0;
      rd_q           <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      imm_q          <= '0;
      dec_sys_q      <= 1'b0;
      dec_ill_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      retired_q      <= retired_d;
      imem_req_q     <= imem_req_d;
      reg_write_q    <= reg_write_d;
      store_enable_q <= store_enable_d;
      mwe_q          <= mwe_d;
      halt_q         <= halt_d;
      illegal_q      <= illegal_d;
      opcode_q       <= opcode_d;
      func3_q        <= func3_d;
      func7_q        <= func7_d;
      rd_q           <= rd_d;
      rs1_q          <= rs1_d;
      rs2_q          <= rs2_d;
      imm_q          <= imm_d;
      dec_sys_q      <= dec_sys_d;
      dec_ill_q      <= dec_ill_d;
    end
  end

  assign imem_req         = imem_req_q;
  assign imem_addr        = pc_q;
  assign pc               = pc_q;
  assign retired          = retired_q;
  assign reg_write        = reg_write_q;
  assign store_enable     = store_enable_q;
  assign mem_write_enable = mwe_q;
  assign halt             = halt_q;
  assign illegal          = illegal_q;
  assign opcode           = opcode_q;
  assign func3            = func3_q;
  assign func7            = func7_q;
  assign rd               = rd_q;
  assign rs1              = rs1_q;
  assign rs2              = rs2_q;
  assign imm              = imm_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Self-checking bench for core_ctrl with a behavioural instruction model.
module tb_core_ctrl;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int C_ALU = 0;
  localparam int C_ST  = 1;
  localparam int C_SYS = 2;
  localparam int C_ILL = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        reg_write;
  logic [4:0]  rd, rs1, rs2;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] imm;
  logic [3:0]  mem_write_enable;
  logic        store_enable;
  logic [31:0] pc;
  logic [31:0] retired;
  logic        halt;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic        first_req;

  core_ctrl #(.RESET_PC(RST_PC)) dut (
    .clock            (clock),
    .reset            (reset),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_valid       (imem_valid),
    .imem_rdata       (imem_rdata),
    .reg_write        (reg_write),
    .rd               (rd),
    .rs1              (rs1),
    .rs2              (rs2),
    .opcode           (opcode),
    .func3            (func3),
    .func7            (func7),
    .imm              (imm),
    .mem_write_enable (mem_write_enable),
    .store_enable     (store_enable),
    .pc               (pc),
    .retired          (retired),
    .halt             (halt),
    .illegal          (illegal)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int f_class(input logic [31:0] w);
    int op, f3, f7;
    op = int'(w[6:0]);
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    if (op == 'h33) begin
      if (f7 == 0) return C_ALU;
      if (f7 == 'h20 && (f3 == 0 || f3 == 5)) return C_ALU;
      return C_ILL;
    end
    if (op == 'h13) return C_ALU;
    if (op == 'h23) return (f3 <= 2) ? C_ST : C_ILL;
    if (op == 'h73) return C_SYS;
    return C_ILL;
  endfunction

  function automatic logic [31:0] f_imm(input logic [31:0] w);
    int v;
    v = 0;
    if (w[6:0] == 7'h13) v = int'(w[31:20]);
    else if (w[6:0] == 7'h23) v = int'(w[31:25]) * 32 + int'(w[11:7]);
    if (v > 2047) v = v - 4096;
    return 32'(v);
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] w);
    return (w[6:0] == 7'h23) ? 5'd0 : w[11:7];
  endfunction

  function automatic logic [4:0] f_rs2(input logic [31:0] w);
    return (w[6:0] == 7'h13) ? 5'd0 : w[24:20];
  endfunction

  function automatic logic [3:0] f_mask(input logic [31:0] w);
    int bytes;
    bytes = 1 << int'(w[14:12]);
    return 4'((1 << bytes) - 1);
  endfunction

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = '0;
    step();
    step();
    reset = 1'b1;
    m_pc = RST_PC;
    m_ret = '0;
    first_req = 1'b0;
  endtask

  // Drive one instruction through the core and check every phase.
  task automatic run_instr(input logic [31:0] w, input int delay);
    int c;
    logic exp_req;
    c = f_class(w);
    for (int i = 0; i <= delay; i++) begin
      exp_req = (i == 0) ? first_req : 1'b1;
      imem_valid = (i == delay);
      imem_rdata = (i == delay) ? w : $urandom;
      checks++;
      if (imem_req !== exp_req) begin errors++; $display("FAIL fetch_req word=%h cyc=%0d got=%b exp=%b", w, i, imem_req, exp_req); end
      checks++;
      if (imem_addr !== m_pc) begin errors++; $display("FAIL fetch_addr word=%h got=%h exp=%h", w, imem_addr, m_pc); end
      checks++;
      if ({reg_write, store_enable, mem_write_enable} !== 6'b0) begin errors++; $display("FAIL fetch_strobes word=%h got=%b exp=0", w, {reg_write, store_enable, mem_write_enable}); end
      step();
    end
    // DECODE cycle: fields visible, nothing strobed
    imem_valid = 1'($urandom);
    imem_rdata = $urandom;
    checks++;
    if ({opcode, func3, func7, rs1} !== {w[6:0], w[14:12], w[31:25], w[19:15]}) begin
      errors++; $display("FAIL dec_fields word=%h got=%h/%h/%h/%h", w, opcode, func3, func7, rs1);
    end
    checks++;
    if ({rd, rs2, imm} !== {f_rd(w), f_rs2(w), f_imm(w)}) begin
      errors++; $display("FAIL dec_rd_rs2_imm word=%h got=%0d/%0d/%h exp=%0d/%0d/%h", w, rd, rs2, imm, f_rd(w), f_rs2(w), f_imm(w));
    end
    checks++;
    if ({imem_req, reg_write, store_enable, halt} !== 4'b0) begin errors++; $display("FAIL dec_quiet word=%h got=%b", w, {imem_req, reg_write, store_enable, halt}); end
    step();
    if (c == C_SYS || c == C_ILL) begin
      checks++;
      if ({halt, illegal} !== {1'b1, (c == C_ILL)}) begin errors++; $display("FAIL halt_flags word=%h got=%b exp=%b", w, {halt, illegal}, {1'b1, (c == C_ILL)}); end
      for (int k = 0; k < 4; k++) begin
        imem_valid = 1'b1;
        imem_rdata = 32'h00500093;
        checks++;
        if ({imem_req, reg_write, store_enable, mem_write_enable} !== 7'b0) begin errors++; $display("FAIL halt_quiet word=%h got=%b exp=0", w, {imem_req, reg_write, store_enable, mem_write_enable}); end
        checks++;
        if ({pc, retired, halt} !== {m_pc, m_ret, 1'b1}) begin errors++; $display("FAIL halt_hold word=%h pc=%h ret=%0d halt=%b exp pc=%h ret=%0d", w, pc, retired, halt, m_pc, m_ret); end
        step();
      end
      imem_valid = 1'b0;
      return;
    end
    // EXEC cycle
    imem_valid = 1'($urandom);
    checks++;
    if ({reg_write, store_enable, halt} !== {(c == C_ALU), 1'b0, 1'b0}) begin errors++; $display("FAIL exec_strobes word=%h got=%b exp=%b", w, {reg_write, store_enable, halt}, {(c == C_ALU), 2'b0}); end
    checks++;
    if ({pc, retired, rd, imm} !== {m_pc, m_ret, f_rd(w), f_imm(w)}) begin errors++; $display("FAIL exec_hold word=%h pc=%h ret=%0d rd=%0d imm=%h", w, pc, retired, rd, imm); end
    step();
    if (c == C_ST) begin
      imem_valid = 1'($urandom);
      checks++;
      if ({store_enable, mem_write_enable, reg_write} !== {1'b1, f_mask(w), 1'b0}) begin errors++; $display("FAIL store_strobe word=%h got=%b exp=%b", w, {store_enable, mem_write_enable, reg_write}, {1'b1, f_mask(w), 1'b0}); end
      checks++;
      if ({rd, rs1, rs2, imm, pc} !== {5'd0, w[19:15], w[24:20], f_imm(w), m_pc}) begin errors++; $display("FAIL store_fields word=%h rd=%0d rs1=%0d rs2=%0d imm=%h pc=%h", w, rd, rs1, rs2, imm, pc); end
      step();
    end
    imem_valid = 1'b0;
    m_pc = m_pc + 32'd4;
    m_ret = m_ret + 32'd1;
    first_req = 1'b1;
    checks++;
    if ({reg_write, store_enable, mem_write_enable, imem_req} !== 7'b0000001) begin errors++; $display("FAIL retire_strobes word=%h got=%b exp=0000001", w, {reg_write, store_enable, mem_write_enable, imem_req}); end
    checks++;
    if ({pc, retired} !== {m_pc, m_ret}) begin errors++; $display("FAIL retire_count word=%h pc=%h ret=%0d exp pc=%h ret=%0d", w, pc, retired, m_pc, m_ret); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 32'h00500093;
    step();
    checks++;
    if ({pc, imem_addr, retired} !== {RST_PC, RST_PC, 32'd0}) begin errors++; $display("FAIL reset_pc pc=%h addr=%h ret=%0d", pc, imem_addr, retired); end
    checks++;
    if ({imem_req, reg_write, store_enable, mem_write_enable, halt, illegal} !== 9'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=0", {imem_req, reg_write, store_enable, mem_write_enable, halt, illegal});
    end
    checks++;
    if ({rd, rs1, rs2, opcode, func3, func7, imm} !== 64'b0) begin errors++; $display("FAIL reset_fields got=%h exp=0", {rd, rs1, rs2, opcode, func3, func7, imm}); end
    imem_valid = 1'b0;
  endtask

  task automatic test_addi_sw_wrap();
    do_reset();
    run_instr(32'h00500093, 0);   // ADDI x1,x0,5
    run_instr(32'h0020A423, 0);   // SW x2,8(x1); pc wraps to 0 here
    checks++;
    if (pc !== 32'h0000_0000) begin errors++; $display("FAIL pc_wrap got=%h exp=00000000", pc); end
  endtask

  task automatic test_fetch_wait();
    run_instr(32'h002081B3, 5);   // ADD x3,x1,x2 after a 5-cycle wait
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [11:0] im;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      im = 12'($urandom);
      case ($urandom % 3)
        0: begin
          f7 = ($urandom % 2) ? 7'h20 : 7'h00;
          f3 = (f7 == 7'h20) ? (($urandom % 2) ? 3'd5 : 3'd0) : 3'($urandom);
          w = {f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), 7'h33};
        end
        1: w = {im, 5'($urandom), 3'($urandom), 5'($urandom), 7'h13};
        default: w = {im[11:5], 5'($urandom), 5'($urandom), 3'($urandom % 3), im[4:0], 7'h23};
      endcase
      run_instr(w, int'($urandom % 4));
    end
  endtask

  task automatic test_illegal();
    logic [31:0] bad [5];
    bad[0] = 32'hFFFF_FFFF;
    bad[1] = 32'h0020B423;   // store func3=3
    bad[2] = 32'h022081B3;   // R-type func7=0x01
    bad[3] = 32'h402091B3;   // R-type func7=0x20, func3=1
    bad[4] = 32'h0000A083;   // load opcode, unsupported
    for (int i = 0; i < 5; i++) begin
      do_reset();
      run_instr(32'h00500093, 0);
      run_instr(bad[i], int'($urandom % 3));
    end
  endtask

  task automatic test_ecall();
    do_reset();
    run_instr(32'h00500093, 1);
    run_instr(32'h00000073, 2);
  endtask

  task automatic test_reset_mid_exec();
    do_reset();
    run_instr(32'h00500093, 0);
    imem_valid = 1'b1;
    imem_rdata = 32'h002081B3;
    step();
    imem_valid = 1'b0;
    step();
    checks++;
    if (reg_write !== 1'b1) begin errors++; $display("FAIL mid_exec_pre got=%b exp=1", reg_write); end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({reg_write, imem_req, pc, retired} !== {2'b00, RST_PC, 32'd0}) begin
      errors++; $display("FAIL async_drop rw=%b req=%b pc=%h ret=%0d", reg_write, imem_req, pc, retired);
    end
    step();
    reset = 1'b1;
    step();
    checks++;
    if ({imem_addr, retired, reg_write} !== {RST_PC, 32'd0, 1'b0}) begin
      errors++; $display("FAIL restart addr=%h ret=%0d rw=%b exp addr=%h", imem_addr, retired, reg_write, RST_PC);
    end
  endtask

  initial begin
    test_reset();
    test_addi_sw_wrap();
    test_fetch_wait();
    test_random();
    test_illegal();
    test_ecall();
    test_reset_mid_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_ctrl.md
Name: core_ctrl

Overview:
- Multi-cycle sequencer for the RV32 datapath (register file, ALU, store unit, data memory).
- Owns the PC and fetches 32-bit instructions over a request/valid instruction port.
- Decodes each instruction and drives the datapath control inputs for one instruction at a time.
- Supported: R-type ALU (0110011), I-type ALU (0010011), stores SB/SH/SW (0100011), SYSTEM (1110011) as halt. All other opcodes stop the core as illegal.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- imem_req  output  1  instruction fetch request.
- imem_addr  output  32  fetch address (= pc).
- imem_valid  input  1  imem_rdata is valid this cycle.
- imem_rdata  input  32  fetched instruction word.
- reg_write  output  1  register file write enable.
- rd, rs1, rs2  output  5 each  register indices.
- opcode  output  7  instruction opcode.
- func3  output  3  instruction func3.
- func7  output  7  instruction func7.
- imm  output  32  sign-extended immediate.
- mem_write_enable  output  4  byte-lane mask.
- store_enable  output  1  data memory write strobe.
- pc  output  32  current PC.
- retired  output  32  retired-instruction counter.
- halt  output  1  core stopped (sticky).
- illegal  output  1  stop cause was an illegal instruction (sticky).

Behaviour:
Reset (reset=0, asynchronous):
- State=FETCH, pc=RESET_PC.
- All other outputs 0, including imem_req.

FETCH:
- imem_req=1, imem_addr=pc.
- On a cycle with imem_valid=1: latch imem_rdata into the instruction register, drop imem_req next cycle, go to DECODE.
- imem_valid while not in FETCH is ignored.
- Wait is unbounded.

DECODE (1 cycle):
- Register opcode=ir[6:0], func3=ir[14:12], func7=ir[31:25], rs1=ir[19:15].
- rd=ir[11:7], forced to 0 for stores.
- rs2=ir[24:20], forced to 0 for I-type.
- imm:
  - I-type: sign-extend ir[31:20].
  - S-type: sign-extend {ir[31:25], ir[11:7]}.
  - Otherwise 0.
- Illegal when any of:
  - unknown opcode;
  - store with func3>2;
  - R-type with func7 not in {0x00, 0x20};
  - R-type with func7=0x20 and func3 not in {0, 5}.
- Transitions: illegal -> HALT with illegal=1. SYSTEM -> HALT with illegal=0. Otherwise -> EXEC.

EXEC (1 cycle):
- R/I: reg_write=1 for exactly this cycle; pc<=pc+4; retired<=retired+1; -> FETCH.
- Store: -> STORE; no reg_write.

STORE (1 cycle):
- store_enable=1 for exactly this cycle.
- mem_write_enable: SB=4'b0001, SH=4'b0011, SW=4'b1111. Lane shifting is the store unit/memory's job.
- pc<=pc+4; retired<=retired+1; -> FETCH.

HALT:
- Absorbing until reset.
- All strobes (reg_write, store_enable, mem_write_enable, imem_req) held 0.
- pc holds the address of the halting instruction.
- retired does not count the halting instruction.

Outputs and control timing:
- All outputs are registered.
- Decoded fields hold their values from DECODE through the end of EXEC/STORE, so the datapath sees them stable for at least one full cycle before and during each strobe.
- reg_write and store_enable are never high in the same cycle.

Arithmetic:
- pc and retired wrap modulo 2^32 (0xFFFF_FFFC+4 = 0).

Latency:
- ALU instruction: 3 cycles minimum (imem_valid in the first FETCH cycle).
- Store: 4 cycles minimum.

Reset during an instruction:
- Any in-flight strobe is dropped immediately (asynchronously).
- No partial writeback.
- Fetch restarts at RESET_PC.

Decomposition:
- Package core_ctrl_pkg:
  - opcode constants OP_R, OP_I, OP_S, OP_SYS;
  - store func3 constants SB/SH/SW;
  - state enum FETCH/DECODE/EXEC/STORE/HALT;
  - byte-mask constants.
- Sub-module instr_decode: combinational field extraction, imm generation and illegal check. core_ctrl instantiates it and registers its outputs in DECODE.

Test Plan:
- Reset release with imem_valid tied 1 and stream ADDI x1,x0,5 (0x00500093) -> reg_write=1 with rd=1, imm=5 in cycle 3; pc=4; retired=1.
- SW x2,8(x1) (0x0020A423) -> STORE cycle shows store_enable=1, mem_write_enable=4'b1111, imm=8, rs1=1, rs2=2, rd=0, reg_write=0; pc+4.
- imem_valid delayed 5 cycles -> imem_req held 5 cycles, no strobes, imem_addr stable; instruction then completes normally.
- 0xFFFFFFFF fetched -> halt=1, illegal=1, pc unchanged, retired unchanged. Further imem_valid pulses -> no activity.
- ECALL (0x00000073) -> halt=1, illegal=0.
- reset driven low mid-EXEC of ADD -> reg_write falls same cycle without a clock edge; after release, imem_addr=RESET_PC and retired=0.
